// File: rtl/freq_meter_ctrl.sv
// Frequency meter front end: rising-crossing detector with hysteresis, period
// counter, and operand/result sequencing for a shared iterative 32-bit divider.
module freq_meter_ctrl #(
  parameter int unsigned SAMPLE_W   = 8,
  parameter logic [31:0] SAMPLE_HZ  = 32'd1000000,
  parameter int unsigned MIN_PERIOD = 4,
  parameter logic [31:0] TIMEOUT    = 32'd1000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_en,
  input  logic [SAMPLE_W-1:0] level,
  input  logic [SAMPLE_W-1:0] hyst,
  output logic [31:0]         div_dividend,
  output logic [31:0]         div_divisor,
  input  logic [31:0]         div_quotient,
  input  logic                div_valid,
  output logic [31:0]         freq_hz,
  output logic                freq_valid,
  output logic                no_signal,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  // Divider handshake: div_valid high means the divider is idle or holding a
  // result, and it loads div_dividend/div_divisor on every edge where it is
  // high. ARM waits for such an edge (operands loaded), RUN waits for the next
  // one (result ready). Operands never change while ARM or RUN.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);
  localparam logic [31:0] TO_LAST = TIMEOUT - 32'd1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_armed;
  logic          r_seen;
  logic [31:0]   r_cnt;
  logic [31:0]   r_dividend;
  logic [31:0]   r_divisor;
  logic [31:0]   r_freq_hz;
  logic          r_freq_valid;
  logic          r_no_signal;

  logic [SAMPLE_W-1:0] w_thresh;
  logic                w_at_level;
  logic                w_below_thr;
  logic                w_cross;
  logic                w_cnt_max;
  logic [31:0]         w_period;
  logic                w_short;
  logic                w_idle;
  logic                w_accept;
  logic                w_timeout;
  logic                w_capture;

  // Re-arm threshold saturates at zero when hysteresis exceeds the level.
  assign w_thresh    = (level > hyst) ? (level - hyst) : '0;
  assign w_at_level  = (sample_in >= level);
  assign w_below_thr = (sample_in <= w_thresh);
  assign w_cross     = sample_en & r_armed & w_at_level;

  assign w_cnt_max   = &r_cnt;
  assign w_period    = w_cnt_max ? r_cnt : (r_cnt + 32'd1);
  assign w_short     = (w_period < MIN_P);
  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_cross & r_seen & ~w_short & w_idle;
  assign w_timeout   = sample_en & ~w_cross & (r_cnt == TO_LAST);
  assign w_capture   = (r_state == ST_RUN) & div_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_ARM;
      ST_ARM:  if (div_valid) w_state_nxt = ST_RUN;
      ST_RUN:  if (div_valid) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_seen       <= 1'b0;
      r_cnt        <= '0;
      r_dividend   <= SAMPLE_HZ;
      r_divisor    <= 32'd1;
      r_freq_hz    <= '0;
      r_freq_valid <= 1'b0;
      r_no_signal  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_freq_valid <= 1'b0;

      // A sample at/above level never arms, so a crossing always clears armed.
      if (sample_en) begin
        if (w_cross)
          r_armed <= 1'b0;
        else if (w_below_thr && !w_at_level)
          r_armed <= 1'b1;

        if (w_cross || w_timeout)
          r_cnt <= '0;
        else if (!w_cnt_max)
          r_cnt <= r_cnt + 32'd1;
      end

      if (w_timeout)
        r_seen <= 1'b0;
      else if (w_cross)
        r_seen <= 1'b1;

      if (w_accept) begin
        r_dividend <= SAMPLE_HZ;
        r_divisor  <= w_period;
      end

      // A timeout while a division is in flight defers its pulse to the result.
      if (w_capture) begin
        r_freq_hz    <= div_quotient;
        r_freq_valid <= 1'b1;
        r_no_signal  <= 1'b0;
      end else if (w_timeout) begin
        r_no_signal <= 1'b1;
        if (w_idle) begin
          r_freq_hz    <= '0;
          r_freq_valid <= 1'b1;
        end
      end
    end
  end

  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign freq_hz      = r_freq_hz;
  assign freq_valid   = r_freq_valid;
  assign no_signal    = r_no_signal;
  assign busy         = (r_state == ST_ARM) | (r_state == ST_RUN);
  assign dbg_state    = r_state;

endmodule
